// File: rtl/debounce_pkg.sv
// Shared definitions for the button debounce / auto-repeat slice.
//
// Contents:
//   state_t                  - repeat FSM states (RELEASED, HELD_WAIT, REPEAT)
//   DEFAULT_DEBOUNCE_CYCLES  - 10 ms at the 25 MHz board clock
//   DEFAULT_HOLD_CYCLES      - 500 ms from press to first auto-repeat step
//   DEFAULT_REPEAT_CYCLES    - 100 ms between auto-repeat steps
//   DEFAULT_CNT_W            - counter width able to hold the largest count
package debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        HELD_WAIT = 2'd1,
        REPEAT    = 2'd2
    } state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
    localparam int DEFAULT_HOLD_CYCLES     = 12500000;
    localparam int DEFAULT_REPEAT_CYCLES   = 2500000;
    localparam int DEFAULT_CNT_W           = 24;

endpackage

// File: rtl/debounce_filter.sv
// Contact-bounce filter: the registered level only follows syncSignal once
// DEBOUNCE_CYCLES consecutive samples disagree with it. Any agreeing sample
// restarts the count.
//
// Ports:
//   clk            system clock
//   reset          synchronous active-high reset
//   syncSignal     synchronised raw button level (1 = pressed)
//   level          debounced level, registered
//   press_pulse    one-cycle pulse in the first cycle level reads 1
//   release_pulse  one-cycle pulse in the first cycle level reads 0
//   riseEvent      combinational: level will rise on this edge
//   fallEvent      combinational: level will fall on this edge
module debounce_filter
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic syncSignal,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic riseEvent,
    output logic fallEvent
);

    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] debCnt;
    logic             flip;

    // The flip decision is exported so the repeat FSM can react on the very
    // edge the level changes, keeping step_pulse aligned with press_pulse.
    always_comb begin
        flip      = (syncSignal != level) && (debCnt == DEB_MAX);
        riseEvent = flip && syncSignal;
        fallEvent = flip && !syncSignal;
    end

    // Debounce counter, level register and edge pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            debCnt        <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= riseEvent;
            release_pulse <= fallEvent;
            if (syncSignal == level) begin
                debCnt <= '0;
            end else if (flip) begin
                level  <= syncSignal;
                debCnt <= '0;
            end else begin
                debCnt <= debCnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_debounce_repeat.sv
// Debounced push-button with single-cycle press/release pulses and an
// auto-repeating step pulse: one step on press, another HOLD_CYCLES later,
// then one every REPEAT_CYCLES while the button stays held and repeat_en=1.
//
// Ports:
//   clk            system clock
//   reset          synchronous active-high reset
//   syncSignal     synchronised raw button level (1 = pressed)
//   repeat_en      1 = auto-repeat enabled, sampled every cycle
//   level          debounced level, registered
//   press_pulse    one cycle on a debounced rise
//   release_pulse  one cycle on a debounced fall
//   step_pulse     one cycle on press and on each auto-repeat
module button_debounce_repeat
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic syncSignal,
    input  logic repeat_en,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic step_pulse
);

    localparam logic [CNT_W-1:0] HOLD_MAX   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_MAX = CNT_W'(REPEAT_CYCLES - 1);

    logic             riseEvent;
    logic             fallEvent;
    state_t           state;
    state_t           stateNext;
    logic [CNT_W-1:0] holdCnt;
    logic [CNT_W-1:0] holdNext;
    logic             stepNext;

    debounce_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) filter (
        .clk           (clk),
        .reset         (reset),
        .syncSignal    (syncSignal),
        .level         (level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .riseEvent     (riseEvent),
        .fallEvent     (fallEvent)
    );

    // State, hold counter and step pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RELEASED;
            holdCnt    <= '0;
            step_pulse <= 1'b0;
        end else begin
            state      <= stateNext;
            holdCnt    <= holdNext;
            step_pulse <= stepNext;
        end
    end

    // A fall overrides everything, including a repeat expiry on the same
    // edge. With repeat_en low the hold count parks at HOLD_MAX so that
    // re-enabling produces a step on the very next edge.
    always_comb begin
        stateNext = state;
        holdNext  = holdCnt;
        stepNext  = 1'b0;
        if (fallEvent) begin
            stateNext = RELEASED;
            holdNext  = '0;
        end else begin
            case (state)
                RELEASED: begin
                    holdNext = '0;
                    if (riseEvent) begin
                        stateNext = HELD_WAIT;
                        stepNext  = 1'b1;
                    end
                end
                HELD_WAIT: begin
                    if (holdCnt >= HOLD_MAX) begin
                        holdNext = HOLD_MAX;
                        if (repeat_en) begin
                            stateNext = REPEAT;
                            holdNext  = '0;
                            stepNext  = 1'b1;
                        end
                    end else begin
                        holdNext = holdCnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!repeat_en) begin
                        stateNext = HELD_WAIT;
                        holdNext  = HOLD_MAX;
                    end else if (holdCnt >= REPEAT_MAX) begin
                        holdNext = '0;
                        stepNext = 1'b1;
                    end else begin
                        holdNext = holdCnt + 1'b1;
                    end
                end
                default: begin
                    stateNext = RELEASED;
                    holdNext  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debounce_repeat.sv
// Self-checking bench for button_debounce_repeat with short timing
// (DEBOUNCE=4, HOLD=10, REPEAT=3). Expected outputs are packed as
// {level, press_pulse, release_pulse, step_pulse}.
module tb_button_debounce_repeat;

    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;

    logic clk = 1'b0;
    logic reset;
    logic syncSignal;
    logic repeat_en;
    logic level;
    logic press_pulse;
    logic release_pulse;
    logic step_pulse;

    int checks = 0;
    int errors = 0;
    int stepCount;

    typedef struct {
        logic       rst;
        logic       sig;
        logic       ren;
        logic [3:0] exp;
        string      name;
    } vec_t;

    typedef struct {
        logic [3:0] exp;
        string      name;
    } expect_t;

    vec_t    vecs[$];
    expect_t sb[$];

    button_debounce_repeat #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP),
        .CNT_W           (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .syncSignal    (syncSignal),
        .repeat_en     (repeat_en),
        .level         (level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .step_pulse    (step_pulse)
    );

    always #5 clk = ~clk;

    function automatic void addVec(input logic rst, input logic sig, input logic ren,
                                   input logic [3:0] exp, input string name);
        vec_t v;
        v.rst  = rst;
        v.sig  = sig;
        v.ren  = ren;
        v.exp  = exp;
        v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput();
        expect_t    e;
        logic [3:0] act;
        act = {level, press_pulse, release_pulse, step_pulse};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard: output %b with no expectation queued", act);
        end else begin
            e = sb.pop_front();
            if (act !== e.exp) begin
                errors++;
                $display("[TB] FAIL %s: lvl/press/rel/step got %b, expected %b", e.name, act, e.exp);
            end
        end
        checks++;
        if (press_pulse && release_pulse) begin
            errors++;
            $display("[TB] FAIL exclusive pulses: press=%b release=%b, expected not both 1",
                     press_pulse, release_pulse);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic sig, input logic ren,
                                 input logic [3:0] exp, input string name);
        expect_t e;
        reset      = rst;
        syncSignal = sig;
        repeat_en  = ren;
        e.exp      = exp;
        e.name     = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        reset      = 1'b1;
        syncSignal = 1'b1;
        repeat_en  = 1'b1;

        $display("[TB] building vector table");
        // Reset with button held, then first debounced rise.
        addVec(1, 1, 1, 4'b0000, "reset edge 1");
        addVec(1, 1, 1, 4'b0000, "reset edge 2");
        addVec(0, 1, 1, 4'b0000, "first cycle after reset");
        addVec(0, 1, 1, 4'b0000, "post-reset debounce 2");
        addVec(0, 1, 1, 4'b0000, "post-reset debounce 3");
        addVec(0, 1, 1, 4'b1101, "post-reset rise");
        addVec(0, 1, 1, 4'b1000, "post-reset held");
        addVec(0, 0, 1, 4'b1000, "post-reset release 1");
        addVec(0, 0, 1, 4'b1000, "post-reset release 2");
        addVec(0, 0, 1, 4'b1000, "post-reset release 3");
        addVec(0, 0, 1, 4'b0010, "post-reset release");
        addVec(0, 0, 1, 4'b0000, "idle");
        // Three-cycle glitch is rejected.
        addVec(0, 1, 1, 4'b0000, "glitch 1");
        addVec(0, 1, 1, 4'b0000, "glitch 2");
        addVec(0, 1, 1, 4'b0000, "glitch 3");
        addVec(0, 0, 1, 4'b0000, "glitch low 1");
        addVec(0, 0, 1, 4'b0000, "glitch low 2");
        // Clean press held five samples, then released.
        addVec(0, 1, 1, 4'b0000, "clean k");
        addVec(0, 1, 1, 4'b0000, "clean k+1");
        addVec(0, 1, 1, 4'b0000, "clean k+2");
        addVec(0, 1, 1, 4'b1101, "clean press k+3");
        addVec(0, 1, 1, 4'b1000, "clean k+4");
        addVec(0, 0, 1, 4'b1000, "clean k+5");
        addVec(0, 0, 1, 4'b1000, "clean k+6");
        addVec(0, 0, 1, 4'b1000, "clean k+7");
        addVec(0, 0, 1, 4'b0010, "clean release k+8");
        addVec(0, 0, 1, 4'b0000, "clean k+9");

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i].rst, vecs[i].sig, vecs[i].ren, vecs[i].exp, vecs[i].name);

        // Long hold with auto-repeat, then a bouncy release whose final
        // sample coincides with a repeat expiry (the fall must win).
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1, 1, 4'b0000, "hold debounce");
        applyStimulus(0, 1, 1, 4'b1101, "hold press");
        stepCount = step_pulse ? 1 : 0;
        for (int j = 1; j <= 29; j++) begin
            logic sig;
            logic expStep;
            sig     = (j <= 21) || (j == 24);
            expStep = (j == 10) || (j == 13) || (j == 16) || (j == 19) || (j == 22) || (j == 25);
            applyStimulus(0, sig, 1, {(j < 28), 1'b0, (j == 28), expStep},
                          $sformatf("hold/bounce press+%0d", j));
            if (j <= 20 && step_pulse)
                stepCount++;
        end
        checks++;
        if (stepCount != 5) begin
            errors++;
            $display("[TB] FAIL step count over 20-cycle hold: got %0d, expected 5", stepCount);
        end

        // repeat_en low during the hold, re-enabled, dropped inside REPEAT,
        // then reset lands on a pending repeat expiry.
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1, 0, 4'b0000, "noRepeat debounce");
        applyStimulus(0, 1, 0, 4'b1101, "noRepeat press");
        for (int j = 1; j <= 29; j++) begin
            logic rst;
            logic ren;
            logic expLvl;
            logic expStep;
            rst     = (j == 25);
            ren     = !((j <= 15) || (j == 20) || (j == 21));
            expLvl  = (j < 25) || (j == 29);
            expStep = (j == 16) || (j == 19) || (j == 22) || (j == 29);
            applyStimulus(rst, 1'b1, ren, {expLvl, (j == 29), 1'b0, expStep},
                          $sformatf("repeatEn/reset press+%0d", j));
        end

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: got %0d left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_debounce_repeat.md
Name: button_debounce_repeat

Overview:
- Consumes the 2-flop-synchronised button level produced by the clock-sync stage and removes contact bounce.
- Emits a debounced level plus single-cycle press, release and step pulses.
- Step pulses auto-repeat while the button is held, so a downstream counter can advance once per press or repeatedly during a long hold.
- Sits between the synchroniser and the slow-clock counter's increment/control logic.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive differing samples needed to flip the level (10 ms @ 25 MHz); must be >= 1.
- HOLD_CYCLES, 12500000, cycles from press pulse to first auto-repeat step (500 ms); must be >= 1.
- REPEAT_CYCLES, 2500000, cycles between successive auto-repeat steps (100 ms); must be >= 1.
- CNT_W, 24, width of the internal counters; must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES) - 1.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- syncSignal  input  1  already-synchronised raw button level (1 = pressed).
- repeat_en  input  1  1 = auto-repeat enabled; sampled every cycle.
- level  output  1  debounced button level, registered.
- press_pulse  output  1  high for one cycle when level goes 0->1.
- release_pulse  output  1  high for one cycle when level goes 1->0.
- step_pulse  output  1  high for one cycle on press, and on each auto-repeat.

Behaviour:
- Reset (synchronous, active-high): level, all pulses and both counters go to 0; FSM goes to RELEASED. Reset takes priority over every other event, including mid-debounce and mid-repeat. No pulse is emitted on the reset edge or on the first cycle after it.
- Debounce counter deb_cnt:
  - If syncSignal == level: deb_cnt <= 0.
  - Otherwise deb_cnt increments.
  - When syncSignal != level and deb_cnt == DEBOUNCE_CYCLES-1: level <= syncSignal and deb_cnt <= 0.
  - Latency: the first differing sample at edge k gives the new level visible after edge k+DEBOUNCE_CYCLES-1.
  - Any single agreeing sample restarts the count.
- Pulses are registered and asserted in the same cycle the new level first appears:
  - press_pulse on a rise.
  - release_pulse on a fall.
  - press_pulse and release_pulse are never high together.
- Repeat FSM (RELEASED, HELD_WAIT, REPEAT) with counter hold_cnt:
  - RELEASED: on a level rise, go to HELD_WAIT with hold_cnt <= 0; step_pulse is asserted with press_pulse.
  - HELD_WAIT: hold_cnt increments each cycle.
    - When hold_cnt == HOLD_CYCLES-1 and repeat_en = 1: go to REPEAT, hold_cnt <= 0, assert step_pulse.
    - If repeat_en = 0, hold_cnt saturates at HOLD_CYCLES-1 and no step is issued. Raising repeat_en later issues a step on the next edge.
  - REPEAT: hold_cnt increments. When hold_cnt == REPEAT_CYCLES-1: assert step_pulse, hold_cnt <= 0.
    - If repeat_en drops, return to HELD_WAIT with hold_cnt saturated. No step is issued.
  - Any level fall, from any state: go to RELEASED, hold_cnt <= 0.
- Simultaneous fall and repeat expiry: the fall wins; no step_pulse, only release_pulse.
- Steps therefore occur at press +0, +HOLD_CYCLES, then every REPEAT_CYCLES after that.
- hold_cnt never wraps. It is reset or saturated before reaching 2^CNT_W.

Decomposition:
- Shared package debounce_pkg:
  - state enum {RELEASED, HELD_WAIT, REPEAT};
  - default timing constants for the 25 MHz board clock.
- Natural sub-module debounce_filter: contains deb_cnt, level, press_pulse and release_pulse.
- The top level keeps the repeat FSM and step_pulse generation.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, repeat_en=1 unless stated):
- Reset asserted 2 cycles with syncSignal=1 -> all outputs 0 during reset and on the next cycle. level rises after edge 4 post-reset, with press_pulse=step_pulse=1 for exactly one cycle.
- syncSignal high 3 cycles then low -> level stays 0; no pulses.
- Clean press, first sampled at edge k, held 5 cycles, then released -> level=1 after edge k+3 with press_pulse and step_pulse for one cycle. Release after 4 low samples gives release_pulse for one cycle, step_pulse=0.
- Hold for 20 cycles after press -> step_pulse at press+0, +10, +13, +16, +19. Exactly 5 steps; the pulses are one cycle wide.
- Release bounce low 2 / high 1 / low 4 -> release_pulse only after the final 4th consecutive low sample. The FSM stays in REPEAT/HELD_WAIT until then.
- repeat_en=0 held 15 cycles after press, then set to 1 -> only the press step, then one step on the edge after repeat_en rises, then every 3 cycles. Reset asserted mid-REPEAT -> no step, outputs 0 the following cycle.
